// File: rtl/t06_rng_pkg.sv
`default_nettype none
// ============================================================================
// Module      : t06_rng_pkg
// Description : Shared types and constants for the RNG request arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package t06_rng_pkg;

   // Arbiter transaction states
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      STROBE  = 3'd1,
      WAIT    = 3'd2,
      CAPTURE = 3'd3,
      RESPOND = 3'd4
   } state_t;

   // Zero-reject retry limit and the counter width that holds it
   localparam int MAX_RETRY = 3;
   localparam int RETRY_W   = 2;

endpackage
`default_nettype wire

// File: rtl/t06_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : t06_rr_pick
// Description : Combinational round-robin picker. Searches the request
//               vector starting one past last_ptr (wrapping) and returns
//               the first set bit as a one-hot grant plus its index.
// Revision    : 1.0  initial release
// ============================================================================
module t06_rr_pick
   import t06_rng_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_in,
   input  logic [PTR_W-1:0]   last_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   winner,
   output logic               any
);

   int               sum;
   logic [PTR_W-1:0] pos;

   // Walk offsets 1..NUM_REQ from last_ptr; first requesting slot wins
   always_comb begin
      grant  = '0;
      winner = '0;
      any    = 1'b0;
      sum    = 0;
      pos    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         sum = int'(last_ptr) + k;
         if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
         end
         pos = PTR_W'(sum);
         if (!any && req_in[pos]) begin
            grant[pos] = 1'b1;
            winner     = pos;
            any        = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/t06_rng_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : t06_rng_request_arbiter
// Description : Shares one random number generator among NUM_REQ requesters
//               with round-robin priority. Each transaction strobes the
//               generator, waits WAIT_CYCLES, captures the value and returns
//               it to the winner with a one-cycle rsp_valid pulse.
//               Optional macro T06_RNG_REJECT_ZERO_EN: a captured zero is
//               re-requested up to MAX_RETRY times, then replaced by 1.
// Revision    : 1.0  initial release
// ============================================================================
module t06_rng_request_arbiter
   import t06_rng_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int WIDTH       = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic               system_clk,
   input  logic               nreset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [NUM_REQ-1:0] rsp_valid,
   output logic [WIDTH-1:0]   rsp_number,
   output logic               rng_enable,
   input  logic [WIDTH-1:0]   rng_number,
   output logic               busy
);

   localparam int                 PTR_W     = $clog2(NUM_REQ);
   localparam int                 WAIT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(NUM_REQ - 1);
   localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);

   state_t             state_q,      state_d;
   logic [NUM_REQ-1:0] gnt_q,        gnt_d;
   logic [NUM_REQ-1:0] rsp_valid_q,  rsp_valid_d;
   logic               rng_enable_q, rng_enable_d;
   logic [WIDTH-1:0]   rsp_number_q, rsp_number_d;
   logic [WAIT_W-1:0]  wait_cnt_q,   wait_cnt_d;
   logic [PTR_W-1:0]   last_ptr_q,   last_ptr_d;
   // Requester served by the previous transaction, blocked for one IDLE cycle
   logic [NUM_REQ-1:0] mask_q,       mask_d;
`ifdef T06_RNG_REJECT_ZERO_EN
   logic [RETRY_W-1:0] retry_cnt_q,  retry_cnt_d;
`endif

   logic [NUM_REQ-1:0] pick_gnt;
   logic [PTR_W-1:0]   pick_idx;
   logic               pick_any;

   t06_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .req_in   (req & ~mask_q),
      .last_ptr (last_ptr_q),
      .grant    (pick_gnt),
      .winner   (pick_idx),
      .any      (pick_any)
   );

   // Next-state and next-output logic; strobe and response pulses are
   // computed one cycle ahead so that they leave the block registered
   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      rsp_valid_d  = '0;
      rng_enable_d = 1'b0;
      rsp_number_d = rsp_number_q;
      wait_cnt_d   = wait_cnt_q;
      last_ptr_d   = last_ptr_q;
      mask_d       = '0;
`ifdef T06_RNG_REJECT_ZERO_EN
      retry_cnt_d  = retry_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               gnt_d        = pick_gnt;
               last_ptr_d   = pick_idx;
               rng_enable_d = 1'b1;
               state_d      = STROBE;
            end
         end
         STROBE: begin
            wait_cnt_d = '0;
            state_d    = WAIT;
         end
         WAIT: begin
            if (wait_cnt_q == WAIT_LAST) begin
               state_d = CAPTURE;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         CAPTURE: begin
`ifdef T06_RNG_REJECT_ZERO_EN
            if (rng_number == '0) begin
               if (retry_cnt_q < RETRY_W'(MAX_RETRY)) begin
                  retry_cnt_d  = retry_cnt_q + 1'b1;
                  rng_enable_d = 1'b1;
                  state_d      = STROBE;
               end else begin
                  rsp_number_d = WIDTH'(1);
                  rsp_valid_d  = gnt_q;
                  state_d      = RESPOND;
               end
            end else begin
               rsp_number_d = rng_number;
               rsp_valid_d  = gnt_q;
               state_d      = RESPOND;
            end
`else
            rsp_number_d = rng_number;
            rsp_valid_d  = gnt_q;
            state_d      = RESPOND;
`endif
         end
         RESPOND: begin
            gnt_d   = '0;
            mask_d  = gnt_q;
            state_d = IDLE;
`ifdef T06_RNG_REJECT_ZERO_EN
            retry_cnt_d = '0;
`endif
         end
         default: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any in-flight transaction
   always_ff @(posedge system_clk or negedge nreset) begin
      if (!nreset) begin
         state_q      <= IDLE;
         gnt_q        <= '0;
         rsp_valid_q  <= '0;
         rng_enable_q <= 1'b0;
         rsp_number_q <= '0;
         wait_cnt_q   <= '0;
         last_ptr_q   <= PTR_LAST;
         mask_q       <= '0;
`ifdef T06_RNG_REJECT_ZERO_EN
         retry_cnt_q  <= '0;
`endif
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         rsp_valid_q  <= rsp_valid_d;
         rng_enable_q <= rng_enable_d;
         rsp_number_q <= rsp_number_d;
         wait_cnt_q   <= wait_cnt_d;
         last_ptr_q   <= last_ptr_d;
         mask_q       <= mask_d;
`ifdef T06_RNG_REJECT_ZERO_EN
         retry_cnt_q  <= retry_cnt_d;
`endif
      end
   end

   assign gnt        = gnt_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_number = rsp_number_q;
   assign rng_enable = rng_enable_q;
   assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire
